prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 83, SHALL give the number of 32-bit words in the target programming shift chain.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port res, input, 1: SHALL be the asynchronous, active-high reset.
REQ-004 Port start, input, 1: SHALL request a load; it SHALL be sampled only in IDLE, DONE or ERR.
REQ-005 Port s_data, input, 32: SHALL carry the bitstream word from the host.
REQ-006 Port s_valid, input, 1: SHALL flag that s_data is valid.
REQ-007 Port s_ready, output, 1: SHALL flag that the loader accepts s_data this cycle.
REQ-008 Port prog_o, output, 32: SHALL drive the chain's prog_i.
REQ-009 Port prog_shft, output, 1: SHALL drive the chain's prog_shft.
REQ-010 Port prog_ret, input, 32: SHALL be the chain's prog_o (last word) for readback.
REQ-011 Port busy, output, 1: SHALL be high in HDR, LOAD and VERIFY.
REQ-012 Port done, output, 1: SHALL be high in DONE.
REQ-013 Port err, output, 2: SHALL hold the error code: 0 none, 1 bad magic, 2 length mismatch, 3 checksum mismatch.

Function
REQ-014 The FSM SHALL have the states IDLE, HDR, LOAD, VERIFY, DONE and ERR.
REQ-015 start in IDLE, DONE or ERR SHALL move to HDR next cycle, clear err and clear the checksum; start in any other state SHALL be ignored.
REQ-016 In HDR, s_ready SHALL be 1; an accepted word (s_valid&&s_ready) SHALL go to LOAD only if [31:16]==16'hB175 and [15:0]==CHAIN_LEN.
REQ-017 A failed header SHALL go to ERR with err=1 for a magic failure, else err=2 for a length failure; prog_shft SHALL stay 0.
REQ-018 In LOAD, s_ready SHALL be 1, prog_o SHALL equal s_data combinationally, and prog_shft SHALL equal s_valid, giving zero-latency shift on accept.
REQ-019 While s_valid is low in LOAD, prog_shft SHALL be 0 (stall) and the word counter SHALL hold.
REQ-020 Each accept SHALL decrement the word counter and update chk = {chk[30:0],chk[31]} ^ word.
REQ-021 The accept of word CHAIN_LEN SHALL leave LOAD next cycle: to VERIFY when PROG_VERIFY_EN is defined, else to DONE.
REQ-022 In VERIFY, s_ready SHALL be 0, prog_shft SHALL be 1 for exactly CHAIN_LEN consecutive cycles, and prog_o SHALL equal prog_ret combinationally (rotation restores the chain).
REQ-023 Each VERIFY cycle SHALL fold prog_ret into a second checksum rchk by the same rule.
REQ-024 After the last VERIFY cycle, the FSM SHALL go to DONE if rchk==chk, else to ERR with err=3.
REQ-025 In IDLE, DONE and ERR, prog_shft, s_ready and prog_o SHALL be 0; err SHALL hold until the next start.
REQ-026 Host words arriving outside HDR and LOAD SHALL NOT be accepted.

Reset
REQ-027 res SHALL force IDLE, counters and checksums to 0, err=0, and busy/done/s_ready/prog_shft/prog_o to 0, immediately and regardless of state.
REQ-028 res mid-LOAD or mid-VERIFY SHALL abandon the operation; the chain contents are undefined and the host SHALL restart.

Configuration
REQ-029 Macro PROG_VERIFY_EN defined SHALL compile in the VERIFY state, rchk and the comparator.
REQ-030 With PROG_VERIFY_EN undefined, LOAD SHALL go directly to DONE, and err=3 SHALL be unreachable.

Structure
REQ-031 Package prog_pkg SHALL hold the state enum, the error-code enum, PROG_MAGIC=16'hB175 and the checksum-step function.
REQ-032 Sub-module prog_chk (clear, enable, 32-bit data in, 32-bit sum out) SHALL implement the checksum accumulator, instanced for chk and rchk.
REQ-033 The counter width SHALL be $clog2(CHAIN_LEN+1).

Verification
REQ-034 CHAIN_LEN=83, header 32'hB175_0053 plus 83 words back-to-back -> prog_shft high on exactly 83 cycles; with verify, 83 more rotate cycles, then done=1, err=0, and the chain holds the payload with word 0 at the last position.
REQ-035 Header 32'hA175_0053 -> ERR, err=1, prog_shft never asserted.
REQ-036 Header 32'hB175_0052 -> ERR, err=2.
REQ-037 s_valid toggled 1-0-1 every cycle during LOAD -> prog_shft mirrors s_valid and the final chain contents are identical to the back-to-back case.
REQ-038 Forced corruption of prog_ret bit 0 on one VERIFY cycle -> ERR, err=3; then start and reload -> done=1, err=0.
REQ-039 res asserted after 40 LOAD words -> all outputs 0 the same cycle; a subsequent full load completes with done=1.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared types, constants and the checksum step for the programming-chain loader.
package prog_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ERR_W  = 2;

    localparam logic [15:0] PROG_MAGIC = 16'hB175;

    // Loader sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        LOAD   = 3'd2,
        VERIFY = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_e;

    // Error codes reported on err
    typedef enum logic [ERR_W-1:0] {
        E_NONE  = 2'd0,
        E_MAGIC = 2'd1,
        E_LEN   = 2'd2,
        E_CHK   = 2'd3
    } err_e;

    // Header word layout: magic in the upper half, chain length in the lower half
    typedef struct packed {
        logic [15:0] magic;
        logic [15:0] len;
    } hdr_t;

    // One checksum step: rotate left by one, then fold in the new word
    function automatic logic [WORD_W-1:0] chk_step(input logic [WORD_W-1:0] sum,
                                                   input logic [WORD_W-1:0] word);
        return {sum[WORD_W-2:0], sum[WORD_W-1]} ^ word;
    endfunction

endpackage

// File: rtl/prog_chk.sv
// Rotate-xor checksum accumulator with synchronous clear and enable.
module prog_chk
    import prog_pkg::*;
(
    input  logic              clk,
    input  logic              res,
    input  logic              clear,
    input  logic              enable,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] sum
);

    // Accumulate one word per enabled cycle; clear wins over enable
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (enable) begin
            sum <= chk_step(sum, data);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a host bitstream into a word-wide programming shift chain.
// A header word (magic + length) is checked, then CHAIN_LEN payload words
// shift straight through to the chain on accept. With PROG_VERIFY_EN defined
// the chain is rotated once more and its output checksum compared with the
// checksum of the loaded words.
module prog_loader
    import prog_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 83
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] prog_o,
    output logic              prog_shft,
    input  logic [WORD_W-1:0] prog_ret,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err
);

    localparam int unsigned      CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);
    localparam logic [15:0]      LEN_FIELD = 16'(CHAIN_LEN);

    state_e            state;
    state_e            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    err_e              err_q;
    err_e              err_nxt;
    logic              busy_q;
    logic              done_q;

    logic              chk_clr;
    logic              chk_en;
    logic [WORD_W-1:0] chk_sum;

    logic              rchk_clr;
    logic              rchk_en;
    logic [WORD_W-1:0] rchk_sum;

    hdr_t              hdr;

    assign hdr = hdr_t'(s_data);

    // Checksum of the words shifted into the chain
    prog_chk u_chk (
        .clk    (clk),
        .res    (res),
        .clear  (chk_clr),
        .enable (chk_en),
        .data   (s_data),
        .sum    (chk_sum)
    );

`ifdef PROG_VERIFY_EN
    // Checksum of the words read back while the chain rotates
    prog_chk u_rchk (
        .clk    (clk),
        .res    (res),
        .clear  (rchk_clr),
        .enable (rchk_en),
        .data   (prog_ret),
        .sum    (rchk_sum)
    );
`else
    logic unused_sig;

    // Readback path is not built; keep its inputs visibly unused
    assign rchk_sum   = '0;
    assign unused_sig = ^{prog_ret, chk_sum, rchk_clr, rchk_en, rchk_sum};
`endif

    // State, counter and registered status flags
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= E_NONE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            err_q  <= err_nxt;
            busy_q <= (state_nxt == HDR) || (state_nxt == LOAD) || (state_nxt == VERIFY);
            done_q <= (state_nxt == DONE);
        end
    end

    // Next-state logic and the zero-latency chain/host handshake
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        chk_clr   = 1'b0;
        chk_en    = 1'b0;
        rchk_clr  = 1'b0;
        rchk_en   = 1'b0;
        s_ready   = 1'b0;
        prog_o    = '0;
        prog_shft = 1'b0;

        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nxt = HDR;
                    err_nxt   = E_NONE;
                    chk_clr   = 1'b1;
                    rchk_clr  = 1'b1;
                end
            end

            HDR: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (hdr.magic != PROG_MAGIC) begin
                        state_nxt = ERR;
                        err_nxt   = E_MAGIC;
                    end else if (hdr.len != LEN_FIELD) begin
                        state_nxt = ERR;
                        err_nxt   = E_LEN;
                    end else begin
                        state_nxt = LOAD;
                        cnt_nxt   = CNT_FULL;
                    end
                end
            end

            LOAD: begin
                s_ready   = 1'b1;
                prog_o    = s_data;
                prog_shft = s_valid;
                if (s_valid) begin
                    chk_en  = 1'b1;
                    cnt_nxt = cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
`ifdef PROG_VERIFY_EN
                        state_nxt = VERIFY;
                        cnt_nxt   = CNT_FULL;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end

`ifdef PROG_VERIFY_EN
            VERIFY: begin
                prog_o    = prog_ret;
                prog_shft = 1'b1;
                rchk_en   = 1'b1;
                cnt_nxt   = cnt - CNT_LAST;
                if (cnt == CNT_LAST) begin
                    // Compare against the sum including this final readback word
                    if (chk_step(rchk_sum, prog_ret) == chk_sum) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = E_CHK;
                    end
                end
            end
`endif

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
